cas_change_logger: RTL and testbench
====================================

# cas_change_logger

Downstream consumer of the `cas` decoder stage. It samples the decoder's `c[2:0]` and `d` outputs every enabled cycle and timestamps each change of the 4-bit value `{d,c}`. Change records are queued in a small FIFO and drained by a ready/valid read port. Bring-up logic or a debug reader uses it to capture decoder activity without stalling the decoder.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `TS_W`, default 8: timestamp width in bits.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `en`  in  1  sample enable; when 0, inputs are ignored and the timestamp holds.
- `c_in`  in  3  decoder output `c`.
- `d_in`  in  1  decoder output `d`.
- `rd_ready`  in  1  reader accepts the head record this cycle.
- `rd_valid`  out  1  head record present (FIFO not empty).
- `rd_data`  out  TS_W+4  head record, packed as `{ts[TS_W-1:0], d, c[2:0]}`.
- `count`  out  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: at least one record was dropped because the FIFO was full.

## Operation
- **Timestamp `ts`**
  - Increments by 1 on every clock edge with `en`=1.
  - Wraps modulo 2^TS_W (for example 8'hFF → 8'h00).
  - Holds when `en`=0.
- **Change detector**
  - Registers `prev[3:0]` and `prev_ok`.
  - On an edge with `en`=1: `prev` ← `{d_in,c_in}` and `prev_ok` ← 1.
  - A log event is generated on an edge with `en`=1 when `prev_ok`=0 (first enabled sample after reset) or when `{d_in,c_in}` ≠ `prev`.
  - Record contents = `{ts` value before this edge's increment`, d_in, c_in}`.
- **FIFO** (circular buffer)
  - Write and read pointers are each log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Empty: pointers equal. Full: pointers differ only in the MSB.
- **Pop**: occurs when `rd_valid` && `rd_ready`; read pointer advances by 1.
- **Push**: occurs on a log event if `count` < DEPTH, or if `count` = DEPTH and a pop occurs the same edge.
- **Drop**: a log event with `count` = DEPTH and no pop discards the record and sets `overflow`=1.
  - `overflow` clears only on reset.
- **Occupancy**: `count` ← `count` + push − pop. A simultaneous push and pop leaves `count` unchanged.
- **Read port**: `rd_valid` = (`count` ≠ 0). `rd_data` = memory at the read pointer (show-ahead).
  - While `rd_valid`=0, `rd_data` is driven to 0.
  - `rd_data` holds stable while `rd_valid`=1 and `rd_ready`=0.
- **Input values**: inputs are 2-state (0/1 only). X/Z on `c_in`/`d_in` is undefined behaviour; the bench drives 0/1 only.

## Timing
- **Reset assertion** (`reset`=0) clears state immediately, without waiting for a clock:
  - `ts`=0, `prev`=4'b0000, `prev_ok`=0, both pointers 0.
  - Outputs: `rd_valid`=0, `rd_data`=0, `count`=0, `overflow`=0.
  - Memory contents are don't-care.
- **Reset deassertion**: first active edge is the first clock edge after `reset` rises.
- **Reset mid-operation**: queued records are lost and `overflow` clears. The next enabled sample is logged unconditionally, since `prev_ok`=0.
- **Latency**: a change present at edge N is visible as `rd_valid`=1 / `rd_data` after edge N. No same-cycle bypass, including when the FIFO was empty.
- **Reader throughput**: one record per cycle with `rd_ready` held at 1.
- **Steady full state**: push and pop on the same edge keep `count`=DEPTH and `overflow`=0.
- **Pointer wrap**: pointers wrap modulo 2·DEPTH. Record order is strictly FIFO across the wrap.

## Test plan
- **First-sample logging**: release reset; `en`=1; hold `{d,c}`=4'b0011 for 5 cycles.
  - Exactly one record: `rd_data`={8'h00,1'b0,3'b011}.
  - `count`=1 after the first edge, then stays 1.
- **Change stream**: `{d,c}` sequence 0011, 0011, 1010, 0011 on edges 0–3 with `rd_ready`=0.
  - Three records, timestamps 0, 2, 3.
  - `count`=3; `overflow`=0.
- **Overflow**: DEPTH=4, `rd_ready`=0, toggle `c_in` 000/111 every cycle for 6 cycles.
  - `count`=4; `overflow`=1.
  - The drained records are the first four, with ts 0..3.
- **Full with concurrent pop**: FIFO full, `rd_ready`=1, one new change.
  - Head pops; new record pushed; `count` stays 4; `overflow` stays 0.
- **Enable and wrap**:
  - `en`=0 for 10 cycles while inputs change → no records, `ts` holds.
  - `en`=1 for 256+ cycles → `ts` wraps 8'hFF→8'h00, and a change at that point logs ts=8'h00.
- **Asynchronous reset**: assert `reset` mid-cycle with `count`=3 and `overflow`=1.
  - `count`=0, `rd_valid`=0, `overflow`=0 before the next clock edge.
  - After release, the first enabled sample is logged with ts=0.

Source files
------------

// File: rtl/cas_change_logger.sv
// cas_change_logger: timestamps every change of the decoder's {d,c} and queues
// the records in a show-ahead FIFO drained through a ready/valid port.
module cas_change_logger #(
    parameter int DEPTH = 4,
    parameter int TS_W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic [2:0]      c_in,
    input  logic            d_in,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [TS_W+3:0] rd_data,
    output logic [AW:0]     count,
    output logic            overflow
);
    logic [TS_W-1:0] ts;
    logic [3:0]      prev;
    logic            prev_ok;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [TS_W+3:0] mem [DEPTH];
    logic [3:0]      cur;
    logic            full, log_ev, pop, push, drop;

    always_comb begin
        cur    = {d_in, c_in};
        count  = wr_ptr - rd_ptr;
        full   = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
        log_ev = en && (!prev_ok || cur != prev);
        pop    = rd_valid && rd_ready;
        push   = log_ev && (!full || pop);
        drop   = log_ev && full && !pop;
    end

    assign rd_valid = wr_ptr != rd_ptr;
    assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts       <= '0;
            prev     <= '0;
            prev_ok  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (en) begin
                ts      <= ts + TS_W'(1);
                prev    <= cur;
                prev_ok <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Record carries the timestamp from before this edge's increment.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {ts, cur};
    end
endmodule

// File: tb/tb_cas_change_logger.sv
// tb_cas_change_logger: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the logger.
module tb_cas_change_logger;
    localparam int DEPTH = 4;
    localparam int TS_W = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  c_in = '0;
    logic        d_in = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic [2:0]  count;
    logic        overflow;

    int total = 0;
    int bad = 0;
    bit started = 0;

    cas_change_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock(clock), .reset(reset), .en(en), .c_in(c_in), .d_in(d_in),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Behavioural model: a queue of records, a wrapping stamp, last sample.
    logic [11:0] q[$];
    logic [7:0]  m_ts;
    logic [3:0]  m_prev;
    bit          m_ok, m_ovf;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_ts = 0;
            m_prev = 0;
            m_ok = 0;
            m_ovf = 0;
        end else begin
            bit ev, pp;
            ev = en && (!m_ok || {d_in, c_in} != m_prev);
            pp = q.size() != 0 && rd_ready;
            if (pp) void'(q.pop_front());
            if (ev) begin
                if (q.size() < DEPTH) q.push_back({m_ts, d_in, c_in});
                else m_ovf = 1;
            end
            if (en) begin
                m_ts = m_ts + 8'd1;
                m_prev = {d_in, c_in};
                m_ok = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            chk("model_valid", 32'(rd_valid), 32'(q.size() != 0));
            chk("model_count", 32'(count), 32'(q.size()));
            chk("model_ovf", 32'(overflow), 32'(m_ovf));
            chk("model_data", 32'(rd_data), q.size() != 0 ? 32'(q[0]) : 32'd0);
        end
    end

    // Apply inputs for the next edge; returns with all earlier edges settled.
    task automatic cyc(input logic e, input logic [3:0] v, input logic r);
        @(negedge clock);
        #1;
        en = e;
        {d_in, c_in} = v;
        rd_ready = r;
    endtask

    task automatic idle();
        cyc(1'b0, {d_in, c_in}, 1'b0);
    endtask

    task automatic pop_chk(input string name, input logic [11:0] exp);
        chk(name, 32'(rd_data), 32'(exp));
        cyc(1'b0, {d_in, c_in}, 1'b1);
        idle();
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b0;
        en = 1'b0;
        rd_ready = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #12;
        reset = 1'b1;
        started = 1;
        // first-sample logging
        cyc(1, 4'b0011, 0);
        cyc(1, 4'b0011, 0);
        chk("first_count1", 32'(count), 32'd1);
        repeat (3) cyc(1, 4'b0011, 0);
        idle();
        chk("first_count", 32'(count), 32'd1);
        chk("first_data", 32'(rd_data), 32'h003);
        // change stream
        do_reset();
        cyc(1, 4'b0011, 0);
        cyc(1, 4'b0011, 0);
        cyc(1, 4'b1010, 0);
        cyc(1, 4'b0011, 0);
        idle();
        chk("stream_count", 32'(count), 32'd3);
        chk("stream_ovf", 32'(overflow), 32'd0);
        pop_chk("stream_r0", 12'h003);
        pop_chk("stream_r1", 12'h02A);
        pop_chk("stream_r2", 12'h033);
        // overflow
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, (i % 2) ? 4'b0111 : 4'b0000, 0);
        idle();
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        pop_chk("ovf_r0", 12'h000);
        pop_chk("ovf_r1", 12'h017);
        pop_chk("ovf_r2", 12'h020);
        pop_chk("ovf_r3", 12'h037);
        chk("ovf_empty", 32'(rd_valid), 32'd0);
        // full with concurrent pop
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, (i % 2) ? 4'b0111 : 4'b0000, 0);
        cyc(1, 4'b0000, 1);
        idle();
        chk("fullpop_count", 32'(count), 32'd4);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        chk("fullpop_head", 32'(rd_data), 32'h017);
        // enable gating and timestamp wrap
        do_reset();
        for (int i = 0; i < 10; i++) cyc(0, 4'($urandom), 0);
        idle();
        chk("en_hold_count", 32'(count), 32'd0);
        for (int i = 0; i < 256; i++) cyc(1, 4'b0101, 1);
        cyc(1, 4'b0110, 0);
        idle();
        chk("wrap_count", 32'(count), 32'd1);
        chk("wrap_data", 32'(rd_data), 32'h006);
        // asynchronous reset mid-cycle
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, (i % 2) ? 4'b0111 : 4'b0000, 0);
        cyc(0, 4'b0000, 1);
        idle();
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clock);
        #1;
        reset = 1'b1;
        cyc(1, 4'b1001, 0);
        idle();
        chk("post_rst_data", 32'(rd_data), 32'h009);
        // random traffic, model checked every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)) | (4'($urandom_range(0, 1)) << 3),
                ($urandom_range(0, 2) == 0));
        end
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
